perceptron_frame_loader: RTL and testbench
==========================================

Name: perceptron_frame_loader

Overview:
- Upstream stage of the perceptron classifier. Receives a byte stream over a valid/ready handshake and parses 3-byte frames: header 0xA5, feature byte 1, feature byte 2.
- Presents the two feature bytes atomically on `inputs1`/`inputs2`.
- Pulses the classifier's synchronous active-low clear (`pe_rst_n`) so the classifier restarts its bit-serial evaluation.
- Holds the features stable for a fixed settle window, then strobes `result_strobe` so the consumer samples the classification.

Parameters:
- HEADER, 8'hA5, frame sync byte.
- RST_CYCLES, 2, cycles `pe_rst_n` is held low after a frame is accepted (≥1).
- SETTLE_CYCLES, 100, cycles in HOLD including the clear; must exceed RST_CYCLES plus worst-case classifier latency (16 bits × 4 cycles + 4).
- TIMEOUT, 255, maximum idle cycles between bytes within a frame.
- CNT_W, 8, width of the hold, gap and statistics counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader can accept a byte
- inputs1  out  8  feature byte 1 to classifier
- inputs2  out  8  feature byte 2 to classifier
- pe_rst_n  out  1  classifier clear, active-low, registered
- result_strobe  out  1  one-cycle pulse: classifier output valid to sample
- busy  out  1  high in HOLD
- frame_count  out  CNT_W  completed frames, wraps
- err_count  out  CNT_W  sync and timeout errors, saturates at all-ones

Behaviour:
- Reset: one clock, rst_n asynchronous active-low. While rst_n is low:
  - state=IDLE; `inputs1`=`inputs2`=0; `pe_rst_n`=0; `result_strobe`=0; `busy`=0.
  - Counters and the shadow byte are 0.
- Reset mid-frame or mid-HOLD aborts the frame; no strobe is emitted.
- `pe_rst_n` stays 0 after reset until the first accepted frame completes its clear window, so the classifier is held cleared.
- Accept = `in_valid` & `in_ready` at a posedge.
- `in_ready` = 1 in IDLE, GET1 and GET2; 0 in HOLD. It is combinational from state only, never from `in_valid`.
- FSM states: IDLE, GET1, GET2, HOLD.
  - IDLE, accept with `in_data`==HEADER: go to GET1, clear the gap counter.
  - IDLE, accept with any other byte: stay in IDLE; `err_count`+1 (saturating); the byte is dropped.
  - GET1, accept: shadow<=`in_data`; go to GET2; clear the gap counter. A HEADER value here is data, not a resync.
  - GET2, accept, all on the same edge:
    - `inputs1`<=shadow, `inputs2`<=`in_data`
    - `pe_rst_n`<=0, hold_cnt<=0
    - go to HOLD.
  - GET1/GET2 with no accept: gap counter +1. When the gap counter reaches TIMEOUT: go to IDLE, `err_count`+1, `inputs1`/`inputs2` unchanged.
  - HOLD: hold_cnt +1 every cycle.
    - `pe_rst_n` returns to 1 on the edge where hold_cnt reaches RST_CYCLES−1, so it is low for exactly RST_CYCLES cycles.
    - When hold_cnt == SETTLE_CYCLES−1: `result_strobe`=1 for that cycle (registered, asserted during the final HOLD cycle); `frame_count`+1 (wraps); next state IDLE.
- `inputs1`/`inputs2` change only on the GET2 accept edge. Both update together; they are never torn.
- `busy` = (state==HOLD), registered with the state.
- Frame throughput: minimum 3 + SETTLE_CYCLES cycles per frame. Back-to-back frames need no idle cycle after HOLD exits.
- Counter widths: the gap and hold counters must hold TIMEOUT and SETTLE_CYCLES. Static assertion: SETTLE_CYCLES > RST_CYCLES.
- No combinational path from `in_data` to any output.

Decomposition:
- Shared package `perceptron_pkg`:
  - the state enum (IDLE/GET1/GET2/HOLD)
  - the HEADER default
  - the classifier worst-case latency constant (68), used to bound SETTLE_CYCLES.
- Sub-module `sat_counter` (parameterised width, inc, saturate/wrap select) instantiated for `err_count` and `frame_count`.
- Everything else is a single FSM module.

Test Plan:
- Reset, then stream A5,09,0A with `in_valid` held → `in_ready` low on the cycle after 0A is accepted; `inputs1`=09 and `inputs2`=0A on that edge; `pe_rst_n` low exactly 2 cycles; `result_strobe` a single pulse 100 cycles after the accept edge; `frame_count`=1.
- Stream 3C,A5,FF,01 → `err_count`=1; frame completes with `inputs1`=FF, `inputs2`=01.
- A5,77, then `in_valid` low for 255 cycles → return to IDLE, `err_count`+1; `inputs1`/`inputs2` keep their previous values; no `result_strobe`.
- A5,A5,A5 → header byte treated as data: `inputs1`=A5, `inputs2`=A5.
- Two frames back-to-back with `in_valid` always 1 → second frame's header accepted on the cycle `result_strobe` deasserts; `frame_count`=2.
- Assert `rst_n` low asynchronously mid-HOLD → outputs return to reset values immediately; no strobe; `frame_count` and `err_count` are 0; 256 bad headers → `err_count` saturates at FF.

Source files
------------

// File: rtl/perceptron_pkg.sv
// Shared types and constants for the perceptron classifier front end.
package perceptron_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GET1 = 2'd1,
        GET2 = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    // 16 feature bits evaluated serially at 4 cycles each, plus pipeline fill.
    localparam int CLASSIFIER_LATENCY = 16 * 4 + 4;

endpackage

// File: rtl/sat_counter.sv
// Event counter with a compile-time choice between saturating and wrapping.
module sat_counter #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic at_max;

    assign at_max = &count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && !(SATURATE && at_max)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/perceptron_frame_loader.sv
// Parses 3-byte frames, loads the feature bytes into the classifier, clears it,
// waits for it to settle and strobes the consumer.
//
//   state | meaning
//   IDLE  | waiting for the header byte; other bytes are errors
//   GET1  | waiting for feature byte 1 (gap timer running)
//   GET2  | waiting for feature byte 2 (gap timer running)
//   HOLD  | features stable, classifier cleared then evaluating
module perceptron_frame_loader
    import perceptron_pkg::*;
#(
    parameter logic [7:0] HEADER        = HEADER_DEFAULT,
    parameter int         RST_CYCLES    = 2,
    parameter int         SETTLE_CYCLES = 100,
    parameter int         TIMEOUT       = 255,
    parameter int         CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       inputs1,
    output logic [7:0]       inputs2,
    output logic             pe_rst_n,
    output logic             result_strobe,
    output logic             busy,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] err_count
);

    if (RST_CYCLES < 1) begin : g_chk_rst
        $error("RST_CYCLES must be at least 1");
    end
    if (SETTLE_CYCLES <= RST_CYCLES) begin : g_chk_settle
        $error("SETTLE_CYCLES must exceed RST_CYCLES");
    end
    if (SETTLE_CYCLES <= RST_CYCLES + CLASSIFIER_LATENCY) begin : g_chk_latency
        $error("SETTLE_CYCLES too short for classifier latency");
    end
    if (TIMEOUT < 1 || TIMEOUT > (2 ** CNT_W) - 1) begin : g_chk_timeout
        $error("TIMEOUT does not fit the gap counter");
    end
    if (SETTLE_CYCLES > (2 ** CNT_W) - 1) begin : g_chk_hold_w
        $error("SETTLE_CYCLES does not fit the hold counter");
    end

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_SET   = CNT_W'(SETTLE_CYCLES - 2);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state;
    logic [7:0]       shadow;
    logic [CNT_W-1:0] gap_cnt;
    logic [CNT_W-1:0] hold_cnt;
    logic             accept;
    logic             in_frame;
    logic             gap_expired;
    logic             err_inc;
    logic             frame_inc;

    assign in_ready    = (state != HOLD);
    assign accept      = in_valid && in_ready;
    assign in_frame    = (state == GET1) || (state == GET2);
    assign gap_expired = in_frame && !accept && (gap_cnt == TIMEOUT_LAST);
    assign err_inc     = ((state == IDLE) && accept && (in_data != HEADER)) || gap_expired;
    assign frame_inc   = (state == HOLD) && (hold_cnt == SETTLE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            shadow        <= '0;
            gap_cnt       <= '0;
            hold_cnt      <= '0;
            inputs1       <= '0;
            inputs2       <= '0;
            pe_rst_n      <= 1'b0;
            result_strobe <= 1'b0;
            busy          <= 1'b0;
        end else begin
            result_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && in_data == HEADER) begin
                        state   <= GET1;
                        gap_cnt <= '0;
                    end
                end
                GET1, GET2: begin
                    if (accept) begin
                        gap_cnt <= '0;
                        if (state == GET1) begin
                            shadow <= in_data;
                            state  <= GET2;
                        end else begin
                            inputs1  <= shadow;
                            inputs2  <= in_data;
                            pe_rst_n <= 1'b0;
                            hold_cnt <= '0;
                            busy     <= 1'b1;
                            state    <= HOLD;
                        end
                    end else if (gap_expired) begin
                        gap_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (hold_cnt == RST_LAST) begin
                        pe_rst_n <= 1'b1;
                    end
                    // Registered one cycle early so the pulse lands in the last HOLD cycle.
                    if (hold_cnt == STROBE_SET) begin
                        result_strobe <= 1'b1;
                    end
                    if (hold_cnt == SETTLE_LAST) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sat_counter #(
        .WIDTH   (CNT_W),
        .SATURATE(1'b1)
    ) u_err_count (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (err_inc),
        .count(err_count)
    );

    sat_counter #(
        .WIDTH   (CNT_W),
        .SATURATE(1'b0)
    ) u_frame_count (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (frame_inc),
        .count(frame_count)
    );

endmodule

// File: tb/tb_perceptron_frame_loader.sv
// Self-checking bench for perceptron_frame_loader: directed sequences, a frame table
// and a randomized byte stream checked against a frame-parsing reference model.
module tb_perceptron_frame_loader;

    localparam int TIMEOUT = 255;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] inputs1;
    logic [7:0] inputs2;
    logic       pe_rst_n;
    logic       result_strobe;
    logic       busy;
    logic [7:0] frame_count;
    logic [7:0] err_count;

    int n_checks = 0;
    int n_fail = 0;
    int strobe_total = 0;
    bit mon_en = 1'b0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    perceptron_frame_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .inputs1      (inputs1),
        .inputs2      (inputs2),
        .pe_rst_n     (pe_rst_n),
        .result_strobe(result_strobe),
        .busy         (busy),
        .frame_count  (frame_count),
        .err_count    (err_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called and returns at a negedge; the byte is accepted on the posedge in between.
    task automatic send_byte(input logic [7:0] b);
        int w = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_byte: in_ready stuck low for byte %0h", b);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_strobe(input string name, input int limit);
        int w = 0;
        while (!result_strobe && w < limit) begin
            @(negedge clk);
            w++;
        end
        if (!result_strobe) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no result_strobe within %0d cycles", name, limit);
        end
    endtask

    always @(negedge clk) begin
        if (result_strobe) strobe_total++;
        if (mon_en && result_strobe) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rand spurious strobe: inputs %0h/%0h with no frame expected", inputs1, inputs2);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                check("rand inputs1", inputs1, e[15:8]);
                check("rand inputs2", inputs2, e[7:0]);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] junk;
        bit         has_junk;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] exp_in1;
        logic [7:0] exp_in2;
        logic [7:0] exp_err;
        logic [7:0] exp_frame;
    } vec_t;

    initial begin
        vec_t vecs[4];
        int   pe_low, strobe_n, strobe_k, s_before, w;
        bit   prev_strobe;
        int   pos, m_err, m_frames;
        logic [7:0] sb, b;
        int   g, r;

        vecs[0] = '{8'h3C, 1'b1, 8'hFF, 8'h01, 8'hFF, 8'h01, 8'd1, 8'd2};
        vecs[1] = '{8'h00, 1'b0, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'd1, 8'd3};
        vecs[2] = '{8'h00, 1'b1, 8'h80, 8'h7F, 8'h80, 8'h7F, 8'd2, 8'd4};
        vecs[3] = '{8'h5A, 1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'd2, 8'd5};

        // Reset values
        repeat (3) @(negedge clk);
        check("reset inputs1", inputs1, 8'h00);
        check("reset inputs2", inputs2, 8'h00);
        check("reset pe_rst_n", pe_rst_n, 1'b0);
        check("reset strobe", result_strobe, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset in_ready", in_ready, 1'b1);
        check("reset frame_count", frame_count, 8'h00);
        check("reset err_count", err_count, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        // First frame: latency of clear window and strobe
        send_byte(8'hA5);
        send_byte(8'h09);
        send_byte(8'h0A);
        in_valid = 1'b0;
        check("f1 in_ready after accept", in_ready, 1'b0);
        check("f1 inputs1", inputs1, 8'h09);
        check("f1 inputs2", inputs2, 8'h0A);
        check("f1 busy", busy, 1'b1);
        pe_low = 0;
        strobe_n = 0;
        strobe_k = 0;
        for (int k = 1; k <= 102; k++) begin
            if (!pe_rst_n) pe_low++;
            if (result_strobe) begin
                strobe_n++;
                strobe_k = k;
            end
            @(negedge clk);
        end
        check("f1 pe_rst_n low cycles", pe_low, 2);
        check("f1 strobe pulses", strobe_n, 1);
        check("f1 strobe cycle", strobe_k, 100);
        check("f1 frame_count", frame_count, 8'd1);
        check("f1 busy after", busy, 1'b0);
        check("f1 err_count", err_count, 8'd0);

        // Table of frames with optional leading junk byte
        for (int i = 0; i < 4; i++) begin
            if (vecs[i].has_junk) send_byte(vecs[i].junk);
            send_byte(8'hA5);
            send_byte(vecs[i].b1);
            send_byte(vecs[i].b2);
            in_valid = 1'b0;
            wait_strobe("table strobe", 150);
            check($sformatf("table[%0d] inputs1", i), inputs1, vecs[i].exp_in1);
            check($sformatf("table[%0d] inputs2", i), inputs2, vecs[i].exp_in2);
            @(negedge clk);
            check($sformatf("table[%0d] err_count", i), err_count, vecs[i].exp_err);
            check($sformatf("table[%0d] frame_count", i), frame_count, vecs[i].exp_frame);
        end

        // Inter-byte timeout: 254 idle cycles is still in frame, 255 aborts
        s_before = strobe_total;
        send_byte(8'hA5);
        send_byte(8'h77);
        idle(254);
        check("timeout err before limit", err_count, 8'd2);
        idle(1);
        check("timeout err at limit", err_count, 8'd3);
        check("timeout inputs1 kept", inputs1, 8'h00);
        check("timeout inputs2 kept", inputs2, 8'hFF);
        check("timeout no strobe", strobe_total, s_before);
        send_byte(8'h10);
        in_valid = 1'b0;
        check("timeout back in idle err", err_count, 8'd4);
        check("timeout back in idle busy", busy, 1'b0);

        // Back-to-back frames with in_valid held high
        send_byte(8'hA5);
        send_byte(8'h11);
        send_byte(8'h22);
        in_data = 8'hA5;
        prev_strobe = 1'b0;
        w = 0;
        while (!in_ready && w < 200) begin
            prev_strobe = result_strobe;
            @(negedge clk);
            w++;
        end
        check("b2b ready returns", in_ready, 1'b1);
        check("b2b strobe low at ready", result_strobe, 1'b0);
        check("b2b strobe high before ready", prev_strobe, 1'b1);
        check("b2b inputs1 first", inputs1, 8'h11);
        @(negedge clk);
        send_byte(8'h33);
        send_byte(8'h44);
        in_valid = 1'b0;
        wait_strobe("b2b strobe", 150);
        check("b2b inputs1", inputs1, 8'h33);
        check("b2b inputs2", inputs2, 8'h44);
        @(negedge clk);
        check("b2b frame_count", frame_count, 8'd7);
        check("b2b err_count", err_count, 8'd4);

        // Asynchronous reset in the middle of HOLD
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h02);
        idle(50);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid reset inputs1", inputs1, 8'h00);
        check("mid reset inputs2", inputs2, 8'h00);
        check("mid reset pe_rst_n", pe_rst_n, 1'b0);
        check("mid reset busy", busy, 1'b0);
        check("mid reset strobe", result_strobe, 1'b0);
        check("mid reset frame_count", frame_count, 8'd0);
        check("mid reset err_count", err_count, 8'd0);
        check("mid reset in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        s_before = strobe_total;
        idle(120);
        check("mid reset no strobe", strobe_total, s_before);
        check("mid reset pe held low", pe_rst_n, 1'b0);

        // Error counter saturation
        in_data  = 8'h3C;
        in_valid = 1'b1;
        repeat (254) @(negedge clk);
        check("sat err 254", err_count, 8'hFE);
        @(negedge clk);
        check("sat err 255", err_count, 8'hFF);
        @(negedge clk);
        check("sat err 256", err_count, 8'hFF);
        in_valid = 1'b0;

        // Randomized stream against the frame-parsing model
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.delete();
        mon_en = 1'b1;
        pos = 0;
        m_err = 0;
        m_frames = 0;
        sb = 8'h00;
        for (int i = 0; i < 50; i++) begin
            r = $urandom_range(0, 9);
            b = (r < 4) ? 8'hA5 : 8'($urandom_range(0, 255));
            r = $urandom_range(0, 19);
            if (r < 13) g = 0;
            else if (r < 18) g = $urandom_range(1, 3);
            else g = 253 + $urandom_range(0, 3);
            if (pos != 0 && g >= TIMEOUT) begin
                if (m_err < 255) m_err++;
                pos = 0;
            end
            if (pos == 0) begin
                if (b == 8'hA5) pos = 1;
                else if (m_err < 255) m_err++;
            end else if (pos == 1) begin
                sb = b;
                pos = 2;
            end else begin
                exp_q.push_back({sb, b});
                m_frames++;
                pos = 0;
            end
            if (g > 0) idle(g);
            send_byte(b);
        end
        idle(120);
        mon_en = 1'b0;
        check("rand frames outstanding", exp_q.size(), 0);
        check("rand frame_count", frame_count, 8'(m_frames));
        check("rand err_count", err_count, 8'(m_err));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
